trig_ratio_engine: RTL and testbench
====================================

Name: trig_ratio_engine

Overview:
- Parametrised, handshaked successor of the fixed 12-bit a*b*cos(c)/(a+d) datapath.
- Computes y = sign(cos c) · ((a·2^W/(a+d)) · (b·|cos c|)) >> scaling, one job at a time.
- The offset d is built by a serial shift-add init phase, which can be re-run at run time.
- The cosine table is external, through a combinational lookup port, so W is not tied to a fixed ROM.

Parameters:
- W, 12, operand width of a, b, c, e and d; also the fraction width of all Q0.W intermediates.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- e  in  W  init operand; sampled in the LOAD state
- reinit  in  1  pulse; when in IDLE, re-runs LOAD+INIT with the current e
- init_done  out  1  high once d is valid and no init is pending
- in_valid  in  1  job request
- in_ready  out  1  high only in IDLE
- a, b, c  in  W each  job operands; c is the cosine table address
- cos_addr  out  W  registered c, driven to the external table
- cos_data  in  W  table output, sign-magnitude: bit W-1 = sign, bits W-2:0 = magnitude Q0.(W-1); combinational from cos_addr
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- y  out  W+1  {sign, magnitude W bits}

Behaviour:
- Reset values:
  - state = LOAD
  - d = 0, counter = 0
  - init_done = 0, in_ready = 0, out_valid = 0
  - y = 0, cos_addr = 0
- A rst asserted mid-job or mid-init aborts it; no partial output is ever presented.
- States: LOAD, INIT, IDLE, LOOK, DIV, MUL, OUT.
- LOAD (1 cycle):
  - e_reg <= e, d <= 0, cnt <= 0.
  - Goes to INIT.
- INIT (W cycles):
  - Each cycle: d <= (d + (e_reg << cnt)) mod 2^W, cnt++.
  - After cnt = W-1 is processed: init_done <= 1, go to IDLE.
  - Net result: d = (e·(2^W-1)) mod 2^W.
  - init_done rises W+1 cycles after rst is released.
- IDLE:
  - in_ready = 1.
  - If in_valid && in_ready at edge T: capture a, b, c (cos_addr <= c) and go to LOOK.
  - Otherwise, if reinit: init_done <= 0 and go to LOAD.
  - If in_valid and reinit are both high, the job wins and reinit is dropped.
  - reinit outside IDLE is ignored.
- LOOK (edge T+1):
  - Capture cos_data.
  - sum = a + d, computed at W+1 bits with no wrap.
  - Load the divider; go to DIV.
- DIV (W cycles, edges T+2..T+W+1):
  - Sequential divide producing q = min(floor(a·2^W / sum), 2^W-1).
  - sum == 0 gives q = 0.
  - a == sum gives q saturated to 2^W-1.
- MUL (edge T+W+2):
  - m = {cos magnitude, 1'b0} (W bits).
  - p = (b·m) >> W (W bits).
  - mag = (q·p) >> W (W bits, truncating).
  - y <= {cos sign, mag}, out_valid <= 1, go to OUT.
- Latency: out_valid is high from edge T+W+2, i.e. accept to result = W+2 cycles.
- OUT:
  - y and out_valid are held stable while out_ready = 0.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE; y keeps its value.
- Throughput: at most 1 job per W+4 cycles. in_ready is low in LOOK, DIV, MUL and OUT; no buffering.
- All products are unsigned. The sign is passed through from cos_data unchanged, including negative zero (y = 1<<W).

Test Plan (W=12):
- Reset/init: rst 2 cycles, e=3 → init_done rises exactly 13 cycles after rst falls; d = 4093 (internal probe); in_ready is 0 until then.
- Basic, e=0:
  - Stimulus: a=100, b=2048, cos_data=0x7FF.
  - Required: q saturates to 4095, p=2047, y=0x07FE.
  - out_valid asserts 14 cycles after the accept edge.
- Negative cos, e=1 (d=4095):
  - Stimulus: a=4095, b=4095, cos_data=0xFFF.
  - Required: q=2048, p=4093, y=0x17FE.
  - With cos_data=0x800 instead, y=0x1000.
- Output backpressure: hold out_ready=0 for 20 cycles → y and out_valid stay stable and in_ready stays 0; one cycle after out_ready=1, in_ready=1.
- Reinit:
  - In IDLE, pulse reinit with e=1 → init_done falls, then rises 13 cycles later; the next job uses d=4095.
  - With in_valid and reinit raised together, the job is accepted and init_done stays 1.
- Abort: assert rst during DIV → next cycle out_valid=0, init_done=0, state=LOAD; no result is emitted for the aborted job.

Source files
------------

// File: rtl/trig_ratio_engine.sv
// Handshaked y = sign(cos c) * ((a*2^W/(a+d)) * (b*|cos c|)) >> scaling engine.
// d comes from a serial shift-add init phase; the cosine table is external.
module trig_ratio_engine #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] e,
  input  logic         reinit,
  output logic         init_done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] cos_addr,
  input  logic [W-1:0] cos_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   y
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_INIT = 3'd1,
    ST_IDLE = 3'd2,
    ST_LOOK = 3'd3,
    ST_DIV  = 3'd4,
    ST_MUL  = 3'd5,
    ST_OUT  = 3'd6
  } state_t;

  state_t          state_r, state_s;
  logic [W-1:0]    e_r, d_r, a_r, b_r, cos_r, q_r;
  logic [W:0]      sum_r, rem_r;
  logic [CW-1:0]   cnt_r;
  logic [W+1:0]    rem_sh_s, rem_nx_s;
  logic            rem_ge_s;
  logic [W-1:0]    m_s, p_s, q_eff_s, mag_s;
  logic [2*W-1:0]  prod_bm_s, prod_qp_s;
  logic            unused_s;

  // Next-state decode; a job request in IDLE takes priority over reinit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOAD: state_s = ST_INIT;
      ST_INIT: begin
        if (cnt_r == CNT_LAST) state_s = ST_IDLE;
        else                   state_s = ST_INIT;
      end
      ST_IDLE: begin
        if (in_valid && in_ready) state_s = ST_LOOK;
        else if (reinit)          state_s = ST_LOAD;
        else                      state_s = ST_IDLE;
      end
      ST_LOOK: state_s = ST_DIV;
      ST_DIV: begin
        if (cnt_r == CNT_LAST) state_s = ST_MUL;
        else                   state_s = ST_DIV;
      end
      ST_MUL: state_s = ST_OUT;
      ST_OUT: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_OUT;
      end
      default: state_s = ST_LOAD;
    endcase
  end

  // Restoring-divide step and the two scaled products.
  // Since sum >= a, a == sum naturally yields all-ones (the saturated value).
  always_comb begin
    rem_sh_s = {rem_r, 1'b0};
    rem_ge_s = (rem_sh_s >= {1'b0, sum_r});
    if (rem_ge_s) rem_nx_s = rem_sh_s - {1'b0, sum_r};
    else          rem_nx_s = rem_sh_s;
    m_s       = {cos_r[W-2:0], 1'b0};
    prod_bm_s = {{W{1'b0}}, b_r} * {{W{1'b0}}, m_s};
    p_s       = prod_bm_s[2*W-1:W];
    if (sum_r == {(W+1){1'b0}}) q_eff_s = {W{1'b0}};
    else                        q_eff_s = q_r;
    prod_qp_s = {{W{1'b0}}, q_eff_s} * {{W{1'b0}}, p_s};
    mag_s     = prod_qp_s[2*W-1:W];
  end

  assign unused_s = ^{rem_nx_s[W+1], prod_bm_s[W-1:0], prod_qp_s[W-1:0]};

  // State register; in_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_LOAD;
      in_ready <= 1'b0;
    end else begin
      state_r  <= state_s;
      in_ready <= (state_s == ST_IDLE);
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_r       <= {W{1'b0}};
      d_r       <= {W{1'b0}};
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      cos_r     <= {W{1'b0}};
      q_r       <= {W{1'b0}};
      sum_r     <= {(W+1){1'b0}};
      rem_r     <= {(W+1){1'b0}};
      cnt_r     <= {CW{1'b0}};
      cos_addr  <= {W{1'b0}};
      y         <= {(W+1){1'b0}};
      init_done <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          e_r   <= e;
          d_r   <= {W{1'b0}};
          cnt_r <= {CW{1'b0}};
        end
        ST_INIT: begin
          d_r <= d_r + (e_r << cnt_r);
          if (cnt_r == CNT_LAST) begin
            init_done <= 1'b1;
            cnt_r     <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            cos_addr <= c;
          end else if (reinit) begin
            init_done <= 1'b0;
          end
        end
        ST_LOOK: begin
          cos_r <= cos_data;
          sum_r <= {1'b0, a_r} + {1'b0, d_r};
          rem_r <= {1'b0, a_r};
          q_r   <= {W{1'b0}};
          cnt_r <= {CW{1'b0}};
        end
        ST_DIV: begin
          rem_r <= rem_nx_s[W:0];
          q_r   <= {q_r[W-2:0], rem_ge_s};
          if (cnt_r == CNT_LAST) cnt_r <= {CW{1'b0}};
          else                   cnt_r <= cnt_r + CNT_ONE;
        end
        ST_MUL: begin
          y         <= {cos_r[W-1], mag_s};
          out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_ratio_engine.sv
// Self-checking bench for trig_ratio_engine: directed plan plus random traffic
// against a cycle-level behavioural model of init, job latency and handshakes.
module tb_trig_ratio_engine;

  localparam int W = 12;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, reinit, in_valid, out_ready;
  logic [W-1:0] e, a, b, c, cos_addr, cos_data;
  logic         init_done, in_ready, out_valid;
  logic [W:0]   y;
  logic [W-1:0] cos_tab [0:(1<<W)-1];

  int tests = 0;
  int fails = 0;

  // model state
  int ec = 0;
  int m_cnt = W + 1;
  int m_out = 0;
  int m_t = 0;
  int m_y = 0;
  int m_d = 0;
  int m_rst = 1;

  trig_ratio_engine #(.W(W)) dut (
    .clk(clk), .rst(rst), .e(e), .reinit(reinit), .init_done(init_done),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c),
    .cos_addr(cos_addr), .cos_data(cos_data), .out_valid(out_valid),
    .out_ready(out_ready), .y(y)
  );

  assign cos_data = cos_tab[cos_addr];

  always #5 clk = ~clk;

  function automatic int ref_y(int ja, int jb, int jcos, int jd);
    longint sum, q, p, mag;
    sum = longint'(ja) + longint'(jd);
    if (sum == 0) q = 0;
    else q = (longint'(ja) << W) / sum;
    if (q > longint'(MASK)) q = longint'(MASK);
    p = (longint'(jb) * longint'((jcos % (1 << (W - 1))) * 2)) >> W;
    mag = (q * p) >> W;
    return ((jcos >> (W - 1)) & 1) * (1 << W) + int'(mag);
  endfunction

  function automatic int d_of(int ee);
    return (ee * MASK) & MASK;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ec);
    end
  endtask

  // Behavioural model: advances on every clock edge from the sampled inputs.
  always @(posedge clk) begin
    ec++;
    m_rst = rst;
    if (rst) begin
      m_cnt = W + 1;
      m_out = 0;
    end else if (m_cnt > 0) begin
      if (m_cnt == W + 1) m_d = d_of(int'(e));
      m_cnt--;
    end else if (m_out != 0) begin
      if (ec - 1 >= m_t + W + 2 && out_ready) m_out = 0;
    end else if (in_valid) begin
      m_out = 1;
      m_t = ec;
      m_y = ref_y(int'(a), int'(b), int'(cos_tab[c]), m_d);
    end else if (reinit) begin
      m_cnt = W + 1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (ec > 0) begin
      if (m_rst != 0) begin
        chk("rst_y", int'(y), 0);
        chk("rst_cos_addr", int'(cos_addr), 0);
      end
      chk("out_valid", int'(out_valid), int'(m_out != 0 && ec >= m_t + W + 2));
      chk("in_ready", int'(in_ready), int'(m_cnt == 0 && m_out == 0));
      chk("init_done", int'(init_done), int'(m_cnt == 0));
      if (m_out != 0 && ec >= m_t + W + 2 && out_valid) chk("y", int'(y), m_y);
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!(m_cnt == 0 && m_out == 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_idle_timeout", int'(k < 300), 1);
  endtask

  task automatic do_reset(input logic [W-1:0] ev);
    rst = 1'b1;
    e = ev;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_job(input int ja, input int jb, input int jc, input int hold, output int yo);
    int k;
    wait_idle();
    out_ready = (hold == 0);
    in_valid = 1'b1;
    a = W'(ja); b = W'(jb); c = W'(jc);
    @(posedge clk); #1 in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); k++;
      @(negedge clk);
    end
    chk("job_latency", k, W + 2);
    yo = int'(y);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_backpressure", int'(in_ready), 1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic count_init(input string name);
    int n = 0;
    while (!init_done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, W + 1);
  endtask

  initial begin
    int yo;
    for (int i = 0; i < (1 << W); i++) cos_tab[i] = W'($urandom);
    rst = 1'b1; reinit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    e = 12'd3; a = 12'd0; b = 12'd0; c = 12'd0;

    chk("model_d_e3", d_of(3), 4093);
    chk("model_basic", ref_y(100, 2048, 'h7FF, 0), 'h07FE);
    chk("model_neg", ref_y(4095, 4095, 'hFFF, 4095), 'h17FE);
    chk("model_negzero", ref_y(4095, 4095, 'h800, 4095), 'h1000);

    // reset and init timing
    do_reset(12'd3);
    count_init("init_latency");
    chk("d_after_init", int'(dut.d_r), 4093);

    // e = 0: q saturates; a = 0 gives sum = 0
    do_reset(12'd0);
    cos_tab[5] = 12'h7FF;
    run_job(100, 2048, 5, 0, yo);
    chk("basic_y", yo, 'h07FE);
    run_job(0, 4095, 5, 0, yo);
    chk("zero_sum_y", yo, 0);

    // e = 1: negative cos, negative zero, output backpressure
    do_reset(12'd1);
    cos_tab[7] = 12'hFFF;
    cos_tab[8] = 12'h800;
    run_job(4095, 4095, 7, 20, yo);
    chk("neg_y", yo, 'h17FE);
    run_job(4095, 4095, 8, 0, yo);
    chk("negzero_y", yo, 'h1000);

    // reinit to e = 3, then back to e = 1
    wait_idle();
    e = 12'd3; reinit = 1'b1;
    @(posedge clk); #1 reinit = 1'b0;
    chk("reinit_drop", int'(init_done), 0);
    count_init("reinit_latency");
    chk("d_after_reinit", int'(dut.d_r), 4093);
    e = 12'd1; reinit = 1'b1;
    @(posedge clk); #1 reinit = 1'b0;
    count_init("reinit2_latency");
    run_job(4095, 4095, 7, 0, yo);
    chk("reinit_job_y", yo, 'h17FE);

    // job and reinit together: job wins
    wait_idle();
    in_valid = 1'b1; reinit = 1'b1; a = 12'd500; b = 12'd4000; c = 12'd7;
    @(posedge clk); #1 in_valid = 1'b0; reinit = 1'b0;
    chk("job_beats_reinit_init_done", int'(init_done), 1);
    chk("job_beats_reinit_in_ready", int'(in_ready), 0);
    wait_idle();

    // abort during DIV
    in_valid = 1'b1; a = 12'd1234; b = 12'd2345; c = 12'd7;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_init_done", int'(init_done), 0);
    chk("abort_state", int'(dut.state_r), 0);
    rst = 1'b0;
    wait_idle();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      reinit    = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 799) == 0);
      e = W'($urandom); a = W'($urandom); b = W'($urandom); c = W'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; reinit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
